// File: rtl/framing_pkg.sv
// Shared framing definitions: sync byte, receive-parser states and the
// byte-parallel CRC-16/MCRF4XX step used by both framer directions.
package framing_pkg;

    localparam logic [7:0] SYNC_CHAR_DEFAULT = 8'h7e;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_SOF,
        ST_SEQ,
        ST_DATA,
        ST_CRC1,
        ST_CRC2,
        ST_EOF
    } state_t;

    // Reflected poly 0x1021 (0x8408), LSB first; caller seeds with 16'hFFFF.
    function automatic logic [15:0] crc16_mcrf4xx_byte(input logic [15:0] crc,
                                                       input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_rx_resync_if.sv
// Read-side message port between the frame receiver and the command parser.
interface frame_rx_resync_if;
    logic [7:0] msg_data;
    logic       msg_eof;
    logic       msg_ready;
    logic       msg_rd_en;

    modport master (output msg_data, output msg_eof, output msg_ready, input msg_rd_en);
    modport slave  (input msg_data, input msg_eof, input msg_ready, output msg_rd_en);
endinterface

// File: rtl/frame_ring.sv
// Payload ring with speculative (tmp) write pointer: bytes of the frame in
// flight are written ahead of wptr and only become visible on commit.
module frame_ring #(
    parameter int RING_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [8:0] wr_data,
    input  logic       commit,
    input  logic       rollback,
    input  logic       rd_en,
    output logic [8:0] rd_data,
    output logic       rd_ready,
    output logic       full,
    output logic       cts
);
    localparam int DEPTH = 1 << RING_BITS;

    typedef logic [RING_BITS-1:0] ptr_t;

    logic [8:0] mem [DEPTH];
    ptr_t       wptr;
    ptr_t       tmp_wptr;
    ptr_t       rptr;
    ptr_t       free_cnt;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tmp_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            tmp_wptr <= '0;
            rptr     <= '0;
        end else if (clr) begin
            wptr     <= '0;
            tmp_wptr <= '0;
            rptr     <= '0;
        end else begin
            if (rollback) begin
                tmp_wptr <= wptr;
            end else if (wr_en) begin
                tmp_wptr <= tmp_wptr + 1'b1;
            end
            if (commit) begin
                wptr <= tmp_wptr;
            end
            if (rd_en && rd_ready) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // One slot always stays empty so that full and empty are distinguishable.
    assign free_cnt = rptr - tmp_wptr - 1'b1;
    assign rd_ready = (rptr != wptr);
    assign full     = ((tmp_wptr + 1'b1) == rptr);
    assign cts      = (free_cnt >= ptr_t'(2));
    assign rd_data  = mem[rptr];

endmodule

// File: rtl/frame_rx_resync.sv
// Receive framer: parses len/seq/data/crc/sync, commits good payloads into
// the ring and recovers from any error by rollback, NAK and re-sync.
module frame_rx_resync
    import framing_pkg::*;
#(
    parameter int         RING_BITS = 8,
    parameter int         MIN_LEN   = 5,
    parameter int         MAX_LEN   = 64,
    parameter logic [7:0] SYNC_CHAR = SYNC_CHAR_DEFAULT,
    parameter logic [3:0] SEQ_HI    = 4'b0001,
    parameter int         CNT_BITS  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    frame_rx_resync_if.master   msg,
    output logic                cts,
    output logic [3:0]          next_seq,
    output logic                nak_req,
    output logic [CNT_BITS-1:0] cnt_ok,
    output logic [CNT_BITS-1:0] cnt_crc_err,
    output logic [CNT_BITS-1:0] cnt_seq_err,
    output logic [CNT_BITS-1:0] cnt_fmt_err,
    input  logic                clr
);
    localparam logic [7:0] MIN_LEN_B = 8'(MIN_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t      state;
    state_t      state_n;
    logic [7:0]  len_q;
    logic [7:0]  seq_q;
    logic [7:0]  rem_q;
    logic [7:0]  crc_hi_q;
    logic [7:0]  crc_lo_q;
    logic [15:0] crc_q;

    logic        byte_in;
    logic        is_sync;
    logic        len_bad;
    logic        seq_bad;
    logic        wr_en;
    logic        commit;
    logic        rollback;
    logic        err_crc;
    logic        err_seq;
    logic        err_fmt;
    logic        ring_full;
    logic        ring_ready;
    logic [8:0]  ring_rd;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // clr wins over a coincident byte, which is simply dropped.
    assign byte_in = rx_valid && !clr;
    assign is_sync = (rx_data == SYNC_CHAR);
    assign len_bad = (rx_data < MIN_LEN_B) || (rx_data >= MAX_LEN_B);
    assign seq_bad = (seq_q[3:0] != next_seq) || (seq_q[7:4] != SEQ_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HUNT;
        end else if (clr) begin
            state <= ST_HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        err_crc  = 1'b0;
        err_seq  = 1'b0;
        err_fmt  = 1'b0;
        if (byte_in) begin
            case (state)
                ST_HUNT: begin
                    if (is_sync) state_n = ST_SOF;
                end
                ST_SOF: begin
                    if (!is_sync) begin
                        if (len_bad) begin
                            err_fmt = 1'b1;
                            state_n = ST_HUNT;
                        end else begin
                            rollback = 1'b1;
                            state_n  = ST_SEQ;
                        end
                    end
                end
                ST_SEQ: begin
                    state_n = (len_q == MIN_LEN_B) ? ST_CRC1 : ST_DATA;
                end
                ST_DATA: begin
                    if (ring_full) begin
                        err_fmt = 1'b1;
                        state_n = ST_HUNT;
                    end else begin
                        wr_en = 1'b1;
                        if (rem_q == 8'd1) state_n = ST_CRC1;
                    end
                end
                ST_CRC1: state_n = ST_CRC2;
                ST_CRC2: state_n = ST_EOF;
                ST_EOF: begin
                    // A sync byte here doubles as the next frame's sync, even on error.
                    if (!is_sync) begin
                        err_fmt = 1'b1;
                        state_n = ST_HUNT;
                    end else if (crc_q != {crc_hi_q, crc_lo_q}) begin
                        err_crc = 1'b1;
                        state_n = ST_SOF;
                    end else if (seq_bad) begin
                        err_seq = 1'b1;
                        state_n = ST_SOF;
                    end else begin
                        commit  = 1'b1;
                        state_n = ST_SOF;
                    end
                end
                default: state_n = ST_HUNT;
            endcase
        end
        if (err_crc || err_seq || err_fmt) rollback = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (byte_in) begin
            case (state)
                ST_SOF: begin
                    len_q <= rx_data;
                    rem_q <= rx_data - MIN_LEN_B;
                    crc_q <= crc16_mcrf4xx_byte(16'hFFFF, rx_data);
                end
                ST_SEQ: begin
                    seq_q <= rx_data;
                    crc_q <= crc16_mcrf4xx_byte(crc_q, rx_data);
                end
                ST_DATA: begin
                    rem_q <= rem_q - 8'd1;
                    crc_q <= crc16_mcrf4xx_byte(crc_q, rx_data);
                end
                ST_CRC1: crc_hi_q <= rx_data;
                ST_CRC2: crc_lo_q <= rx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_seq    <= '0;
            nak_req     <= 1'b0;
            cnt_ok      <= '0;
            cnt_crc_err <= '0;
            cnt_seq_err <= '0;
            cnt_fmt_err <= '0;
        end else if (clr) begin
            next_seq    <= '0;
            nak_req     <= 1'b0;
            cnt_ok      <= '0;
            cnt_crc_err <= '0;
            cnt_seq_err <= '0;
            cnt_fmt_err <= '0;
        end else begin
            nak_req <= err_crc || err_seq || err_fmt;
            if (commit) begin
                next_seq <= seq_q[3:0] + 4'd1;
                cnt_ok   <= sat_inc(cnt_ok);
            end
            if (err_crc) cnt_crc_err <= sat_inc(cnt_crc_err);
            if (err_seq) cnt_seq_err <= sat_inc(cnt_seq_err);
            if (err_fmt) cnt_fmt_err <= sat_inc(cnt_fmt_err);
        end
    end

    frame_ring #(
        .RING_BITS (RING_BITS)
    ) u_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_data  ({rem_q == 8'd1, rx_data}),
        .commit   (commit),
        .rollback (rollback),
        .rd_en    (msg.msg_rd_en),
        .rd_data  (ring_rd),
        .rd_ready (ring_ready),
        .full     (ring_full),
        .cts      (cts)
    );

    assign msg.msg_data  = ring_rd[7:0];
    assign msg.msg_eof   = ring_ready & ring_rd[8];
    assign msg.msg_ready = ring_ready;

endmodule

// File: tb/tb_frame_rx_resync.sv
// Directed plus randomized frame traffic against a frame-level reference
// model (outcome decided per whole frame, payload scoreboard queue).
module tb_frame_rx_resync;

    localparam int K_OK = 0, K_CRC = 1, K_SEQ = 2, K_SEQHI = 3, K_LEN = 4, K_NOSYNC = 5;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [7:0]  rx_data, rx_data_s;
    logic        rx_valid, rx_valid_s;
    logic        cts, cts_s, nak_req, nak_s;
    logic [3:0]  next_seq, next_seq_s;
    logic [15:0] cnt_ok, cnt_crc_err, cnt_seq_err, cnt_fmt_err;
    logic [15:0] cnt_ok_s, cnt_crc_s, cnt_seq_s, cnt_fmt_s;

    frame_rx_resync_if m_if ();
    frame_rx_resync_if s_if ();

    always #5 clk = ~clk;

    frame_rx_resync dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .msg(m_if),
        .cts(cts), .next_seq(next_seq), .nak_req(nak_req), .cnt_ok(cnt_ok),
        .cnt_crc_err(cnt_crc_err), .cnt_seq_err(cnt_seq_err), .cnt_fmt_err(cnt_fmt_err),
        .clr(clr)
    );

    frame_rx_resync #(.RING_BITS(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data_s), .rx_valid(rx_valid_s), .msg(s_if),
        .cts(cts_s), .next_seq(next_seq_s), .nak_req(nak_s), .cnt_ok(cnt_ok_s),
        .cnt_crc_err(cnt_crc_s), .cnt_seq_err(cnt_seq_s), .cnt_fmt_err(cnt_fmt_s),
        .clr(clr)
    );

    int         total = 0;
    int         bad = 0;
    int         naks, naks_s;
    int         e_ok, e_crc, e_seq, e_fmt;
    logic [3:0] e_next;
    bq_t        exp_q;
    bit         exp_eof[$];

    function automatic logic [15:0] ref_crc(input bq_t b);
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        foreach (b[i]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        naks += int'(nak_req);
    endtask

    task automatic send_byte_s(input logic [7:0] b);
        @(negedge clk);
        rx_data_s  = b;
        rx_valid_s = 1'b1;
        @(negedge clk);
        rx_valid_s = 1'b0;
        naks_s += int'(nak_s);
    endtask

    task automatic model_reset();
        e_ok = 0; e_crc = 0; e_seq = 0; e_fmt = 0;
        e_next = 4'd0;
        exp_q.delete();
        exp_eof.delete();
    endtask

    task automatic check_status(input string tag, input int exp_nak);
        chk({tag, ".ok"},   32'(cnt_ok),      32'(e_ok));
        chk({tag, ".crc"},  32'(cnt_crc_err), 32'(e_crc));
        chk({tag, ".seq"},  32'(cnt_seq_err), 32'(e_seq));
        chk({tag, ".fmt"},  32'(cnt_fmt_err), 32'(e_fmt));
        chk({tag, ".next"}, 32'(next_seq),    32'(e_next));
        chk({tag, ".nak"},  32'(naks),        32'(exp_nak));
        chk({tag, ".cts"},  32'(cts),         32'd1);
    endtask

    // Frame-level model: the outcome follows from how the frame was built.
    task automatic send_frame(input string tag, input int kind, input logic [7:0] seq,
                              input bq_t pay, input logic [7:0] badlen);
        bq_t         body;
        logic [15:0] c;
        int          errs = 0;
        body = {8'(pay.size() + 5), seq};
        foreach (pay[i]) body.push_back(pay[i]);
        c = ref_crc(body);
        if (kind == K_CRC) c = c ^ 16'h0001;
        naks = 0;
        send_byte(8'h7e);
        if (kind == K_LEN) begin
            send_byte(badlen);
            send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
            e_fmt++; errs = 1;
        end else begin
            foreach (body[i]) send_byte(body[i]);
            send_byte(c[15:8]);
            send_byte(c[7:0]);
            send_byte((kind == K_NOSYNC) ? 8'h00 : 8'h7e);
            if (kind == K_NOSYNC) begin
                e_fmt++; errs = 1;
            end else if (kind == K_CRC) begin
                e_crc++; errs = 1;
            end else if (seq[3:0] != e_next || seq[7:4] != 4'h1) begin
                e_seq++; errs = 1;
            end else begin
                e_ok++;
                e_next = e_next + 4'd1;
                foreach (pay[i]) begin
                    exp_q.push_back(pay[i]);
                    exp_eof.push_back(i == pay.size() - 1);
                end
            end
        end
        @(negedge clk);
        check_status(tag, errs);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            chk({tag, ".rdy"},  32'(m_if.msg_ready), 32'd1);
            chk({tag, ".data"}, 32'(m_if.msg_data),  32'(exp_q[0]));
            chk({tag, ".eof"},  32'(m_if.msg_eof),   32'(exp_eof[0]));
            m_if.msg_rd_en = 1'b1;
            @(negedge clk);
            m_if.msg_rd_en = 1'b0;
            void'(exp_q.pop_front());
            void'(exp_eof.pop_front());
        end
        @(negedge clk);
        chk({tag, ".empty"}, 32'(m_if.msg_ready), 32'd0);
        chk({tag, ".eof0"},  32'(m_if.msg_eof),   32'd0);
    endtask

    function automatic bq_t rand_pay(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bq_t        pay;
        bq_t        body;
        logic [15:0] c;
        int          kind;
        logic [7:0]  seq, bl;

        rst_n = 1'b0; clr = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; rx_data_s = 8'h00; rx_valid_s = 1'b0;
        m_if.msg_rd_en = 1'b0; s_if.msg_rd_en = 1'b0;
        model_reset();
        #12;
        chk("rst.ready", 32'(m_if.msg_ready), 32'd0);
        chk("rst.eof",   32'(m_if.msg_eof),   32'd0);
        chk("rst.cts",   32'(cts),            32'd1);
        chk("rst.next",  32'(next_seq),       32'd0);
        chk("rst.nak",   32'(nak_req),        32'd0);
        chk("rst.ok",    32'(cnt_ok),         32'd0);
        chk("rst.fmt",   32'(cnt_fmt_err),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        pay = {};
        send_frame("empty", K_OK, 8'h10, pay, 8'h00);
        chk("empty.rdy", 32'(m_if.msg_ready), 32'd0);
        pay = {8'haa, 8'hbb, 8'hcc};
        send_frame("abc", K_OK, 8'h11, pay, 8'h00);
        drain("abc");
        send_frame("crcbad", K_CRC, 8'h12, pay, 8'h00);
        chk("crcbad.rdy", 32'(m_if.msg_ready), 32'd0);
        send_frame("after_crc", K_OK, 8'h12, pay, 8'h00);
        drain("after_crc");
        send_frame("seq15", K_OK, 8'h15, pay, 8'h00);
        send_frame("seqhi", K_OK, {4'h2, e_next}, pay, 8'h00);
        send_frame("len03", K_LEN, 8'h00, pay, 8'h03);
        send_frame("resync", K_OK, {4'h1, e_next}, pay, 8'h00);
        drain("resync");
        send_frame("len64", K_LEN, 8'h00, pay, 8'd64);
        pay = rand_pay(58);
        send_frame("len63", K_OK, {4'h1, e_next}, pay, 8'h00);
        drain("len63");
        send_frame("nosync", K_NOSYNC, {4'h1, e_next}, pay, 8'h00);

        for (int it = 0; it < 120; it++) begin
            kind = int'($urandom_range(0, 5));
            pay  = rand_pay(int'($urandom_range(0, 12)));
            bl   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(64, 255));
            if (bl == 8'h7e) bl = 8'h80;
            case (kind)
                K_SEQ:   seq = {4'h1, 4'(e_next + 4'($urandom_range(1, 15)))};
                K_SEQHI: seq = {4'($urandom_range(2, 17)), e_next};
                K_CRC:   seq = 8'($urandom);
                default: seq = {4'h1, e_next};
            endcase
            send_frame($sformatf("rnd%0d", it), kind, seq, pay, bl);
            drain($sformatf("rnd%0d", it));
        end

        // Small ring: capacity 7, second frame overflows.
        pay = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        body = {8'h0b, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        c = ref_crc(body);
        naks_s = 0;
        send_byte_s(8'h7e);
        foreach (body[i]) send_byte_s(body[i]);
        send_byte_s(c[15:8]); send_byte_s(c[7:0]); send_byte_s(8'h7e);
        @(negedge clk);
        chk("ov1.ok",  32'(cnt_ok_s),         32'd1);
        chk("ov1.rdy", 32'(s_if.msg_ready),   32'd1);
        chk("ov1.cts", 32'(cts_s),            32'd0);
        send_byte_s(8'h7e); send_byte_s(8'h0b); send_byte_s(8'h11);
        send_byte_s(8'h01); send_byte_s(8'h02);
        @(negedge clk);
        chk("ov2.fmt",  32'(cnt_fmt_s),  32'd1);
        chk("ov2.nak",  32'(naks_s),     32'd1);
        chk("ov2.ok",   32'(cnt_ok_s),   32'd1);
        chk("ov2.next", 32'(next_seq_s), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("ov.rdy",  32'(s_if.msg_ready), 32'd1);
            chk("ov.data", 32'(s_if.msg_data),  32'(pay[i]));
            chk("ov.eof",  32'(s_if.msg_eof),   32'(i == 5));
            s_if.msg_rd_en = 1'b1;
            @(negedge clk);
            s_if.msg_rd_en = 1'b0;
        end
        @(negedge clk);
        chk("ov.empty", 32'(s_if.msg_ready), 32'd0);

        // Async reset in the middle of a frame, with committed bytes pending.
        pay = {8'h5a, 8'ha5};
        send_frame("pre_rst", K_OK, {4'h1, e_next}, pay, 8'h00);
        send_byte(8'h7e); send_byte(8'h08); send_byte({4'h1, e_next}); send_byte(8'haa);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.ready", 32'(m_if.msg_ready), 32'd0);
        chk("arst.eof",   32'(m_if.msg_eof),   32'd0);
        chk("arst.cts",   32'(cts),            32'd1);
        chk("arst.next",  32'(next_seq),       32'd0);
        chk("arst.ok",    32'(cnt_ok),         32'd0);
        chk("arst.crc",   32'(cnt_crc_err),    32'd0);
        chk("arst.seq",   32'(cnt_seq_err),    32'd0);
        chk("arst.fmt",   32'(cnt_fmt_err),    32'd0);
        chk("arst.nak",   32'(nak_req),        32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pay = {8'h31, 8'h32, 8'h33, 8'h34};
        send_frame("post_rst", K_OK, 8'h10, pay, 8'h00);
        drain("post_rst");

        // clr together with a sync byte: clr wins, byte dropped, parser hunts.
        pay = {8'h77};
        send_frame("pre_clr", K_OK, {4'h1, e_next}, pay, 8'h00);
        @(negedge clk);
        clr = 1'b1; rx_data = 8'h7e; rx_valid = 1'b1;
        @(negedge clk);
        clr = 1'b0; rx_valid = 1'b0;
        model_reset();
        chk("clr.ok",    32'(cnt_ok),         32'd0);
        chk("clr.next",  32'(next_seq),       32'd0);
        chk("clr.ready", 32'(m_if.msg_ready), 32'd0);
        body = {8'h05, 8'h10};
        c = ref_crc(body);
        naks = 0;
        send_byte(8'h05); send_byte(8'h10); send_byte(c[15:8]); send_byte(c[7:0]); send_byte(8'h7e);
        @(negedge clk);
        check_status("clr_drop", 0);
        pay = {8'h99, 8'h88};
        send_frame("post_clr", K_OK, 8'h10, pay, 8'h00);
        drain("post_clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
